uart_frame_parser: RTL and testbench

//  Downstream of uart_rx: turns its raw byte stream (data + level valid) into checked command frames.

---
 rtl/uart_frame_pkg.sv | 17 +
 rtl/uart_byte_strobe.sv | 28 ++
 rtl/uart_frame_parser.sv | 217 +++++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg
//   Shared definitions for the UART command-frame parser:
//   - SOF_BYTE      : start-of-frame marker that opens every frame
//   - frame_state_t : parser FSM states
package uart_frame_pkg;

  localparam logic [7:0] SOF_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHK
  } frame_state_t;

endpackage

// File: rtl/uart_byte_strobe.sv
// uart_byte_strobe
//   Converts the level-style valid from uart_rx into a one-cycle byte strobe
//   on its rising edge, so a valid held high for many cycles counts once.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   in_valid in   level valid from uart_rx
//   strobe   out  one-cycle pulse on the rising edge of in_valid (combinational)
module uart_byte_strobe (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic strobe
);

  logic r_in_valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_valid_d <= 1'b0;
    end else begin
      r_in_valid_d <= in_valid;
    end
  end

  assign strobe = in_valid & ~r_in_valid_d;

endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Parses the uart_rx byte stream into checked command frames:
//     SOF(0xA5) CMD LEN payload[LEN] CHK, CHK = XOR of CMD, LEN and payload.
//   A good frame is held (frame_valid) with its payload readable through
//   rd_addr/rd_data until the consumer acknowledges it with frame_ack.
//   Bytes arriving while a frame is held are discarded with a drop pulse.
// Optional build macro:
//   UART_FRAME_TIMEOUT_EN : enables the inter-byte timeout (err_timeout);
//                           without it err_timeout is tied low.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_data, in_valid   byte stream from uart_rx (level valid)
//   frame_valid         good frame held for the consumer
//   frame_cmd/frame_len CMD byte and payload length of the held frame
//   rd_addr, rd_data    combinational payload read port
//   frame_ack           releases the held frame
//   err_chk/err_len     one-cycle pulses: checksum mismatch / LEN too large
//   err_timeout         one-cycle pulse: inter-byte timeout
//   drop                one-cycle pulse: byte discarded while frame held
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         frame_valid,
  output logic [7:0]                   frame_cmd,
  output logic [$clog2(MAX_LEN+1)-1:0] frame_len,
  input  logic [$clog2(MAX_LEN)-1:0]   rd_addr,
  output logic [7:0]                   rd_data,
  input  logic                         frame_ack,
  output logic                         err_chk,
  output logic                         err_len,
  output logic                         err_timeout,
  output logic                         drop
);

  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int ADDR_W = $clog2(MAX_LEN);

  // Elaboration-time sanity checks on the configuration.
  if (MAX_LEN < 2 || MAX_LEN > 255) begin : g_bad_max_len
    $error("uart_frame_parser: MAX_LEN must be in 2..255");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_frame_parser: TIMEOUT_CYCLES must be >= 2");
  end

  frame_state_t     r_state, w_state_next;
  logic [7:0]       r_cmd, w_cmd_next;
  logic [LEN_W-1:0] r_len, w_len_next;
  logic [LEN_W-1:0] r_idx, w_idx_next;
  logic [LEN_W-1:0] w_idx_inc;
  logic [7:0]       r_chk, w_chk_next;
  logic             r_frame_valid, w_frame_valid_next;
  logic [7:0]       r_frame_cmd, w_frame_cmd_next;
  logic [LEN_W-1:0] r_frame_len, w_frame_len_next;
  logic             r_err_chk, w_err_chk_next;
  logic             r_err_len, w_err_len_next;
  logic             r_err_timeout, w_err_timeout_next;
  logic             r_drop, w_drop_next;
  logic             w_buf_we;
  logic             w_strobe;
  logic             w_timeout;
  logic [7:0]       r_buf [MAX_LEN];

  uart_byte_strobe u_strobe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .strobe   (w_strobe)
  );

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;

  // Counts cycles since the last strobe while a frame is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (w_strobe || r_state == S_IDLE) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state != S_IDLE) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign w_idx_inc = r_idx + LEN_W'(1);

  always_comb begin
    w_state_next       = r_state;
    w_cmd_next         = r_cmd;
    w_len_next         = r_len;
    w_idx_next         = r_idx;
    w_chk_next         = r_chk;
    w_frame_valid_next = r_frame_valid & ~frame_ack;
    w_frame_cmd_next   = r_frame_cmd;
    w_frame_len_next   = r_frame_len;
    w_err_chk_next     = 1'b0;
    w_err_len_next     = 1'b0;
    w_err_timeout_next = 1'b0;
    w_drop_next        = 1'b0;
    w_buf_we           = 1'b0;

    if (w_strobe) begin
      // A held frame blocks reception entirely; an ack in the same cycle
      // still leaves this byte dropped. The FSM is always IDLE here.
      if (r_frame_valid) begin
        w_drop_next = 1'b1;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (in_data == SOF_BYTE) begin
              w_state_next = S_CMD;
            end
          end
          S_CMD: begin
            w_cmd_next   = in_data;
            w_chk_next   = in_data;
            w_state_next = S_LEN;
          end
          S_LEN: begin
            if (in_data > 8'(MAX_LEN)) begin
              w_err_len_next = 1'b1;
              w_state_next   = S_IDLE;
            end else begin
              w_len_next   = in_data[LEN_W-1:0];
              w_chk_next   = r_chk ^ in_data;
              w_idx_next   = '0;
              w_state_next = (in_data == 8'h00) ? S_CHK : S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            w_buf_we   = 1'b1;
            w_chk_next = r_chk ^ in_data;
            w_idx_next = w_idx_inc;
            if (w_idx_inc == r_len) begin
              w_state_next = S_CHK;
            end
          end
          S_CHK: begin
            if (in_data == r_chk) begin
              w_frame_valid_next = 1'b1;
              w_frame_cmd_next   = r_cmd;
              w_frame_len_next   = r_len;
            end else begin
              w_err_chk_next = 1'b1;
            end
            w_state_next = S_IDLE;
          end
          default: w_state_next = S_IDLE;
        endcase
      end
    end else if (w_timeout) begin
      // Timeout only applies when no byte arrived this cycle.
      w_err_timeout_next = 1'b1;
      w_state_next       = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cmd         <= '0;
      r_len         <= '0;
      r_idx         <= '0;
      r_chk         <= '0;
      r_frame_valid <= 1'b0;
      r_frame_cmd   <= '0;
      r_frame_len   <= '0;
      r_err_chk     <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_drop        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cmd         <= w_cmd_next;
      r_len         <= w_len_next;
      r_idx         <= w_idx_next;
      r_chk         <= w_chk_next;
      r_frame_valid <= w_frame_valid_next;
      r_frame_cmd   <= w_frame_cmd_next;
      r_frame_len   <= w_frame_len_next;
      r_err_chk     <= w_err_chk_next;
      r_err_len     <= w_err_len_next;
      r_err_timeout <= w_err_timeout_next;
      r_drop        <= w_drop_next;
    end
  end

  // Payload storage: not reset, written only while receiving.
  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      r_buf[r_idx[ADDR_W-1:0]] <= in_data;
    end
  end

  assign rd_data     = r_buf[rd_addr];
  assign frame_valid = r_frame_valid;
  assign frame_cmd   = r_frame_cmd;
  assign frame_len   = r_frame_len;
  assign err_chk     = r_err_chk;
  assign err_len     = r_err_len;
  assign err_timeout = r_err_timeout;
  assign drop        = r_drop;

endmodule

// File: tb/tb_uart_frame_parser.sv
module tb_uart_frame_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       frame_valid;
  logic [7:0] frame_cmd;
  logic [4:0] frame_len;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_ack;
  logic       err_chk;
  logic       err_len;
  logic       err_timeout;
  logic       drop;

  int checks   = 0;
  int failures = 0;

  int n_err_chk = 0;
  int n_err_len = 0;
  int n_err_to  = 0;
  int n_drop    = 0;
  int n_shape   = 0;
  logic [3:0] prev_pulse = 4'b0;

  always #5 clk = ~clk;

  uart_frame_parser #(.MAX_LEN(16), .TIMEOUT_CYCLES(200)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .frame_valid (frame_valid),
    .frame_cmd   (frame_cmd),
    .frame_len   (frame_len),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_ack   (frame_ack),
    .err_chk     (err_chk),
    .err_len     (err_len),
    .err_timeout (err_timeout),
    .drop        (drop)
  );

  // Pulse monitor: counts pulses and flags any that overlap or last > 1 cycle.
  always @(negedge clk) begin
    logic [3:0] pulse;
    pulse = {err_chk, err_len, err_timeout, drop};
    if (err_chk)     n_err_chk++;
    if (err_len)     n_err_len++;
    if (err_timeout) n_err_to++;
    if (drop)        n_drop++;
    if (!rst && (($countones(pulse[3:1]) > 1) || ((pulse & prev_pulse) != 4'b0))) n_shape++;
    prev_pulse = pulse;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout: sim time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; valid held for 'hold' cycles, then low for one.
  task automatic send_bytes(input logic [7:0] q[$], input int hold);
    foreach (q[i]) begin
      in_data  = q[i];
      in_valid = 1'b1;
      repeat (hold) @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    checks++;
    if (frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL ack_clear: frame_valid=%b required 0", frame_valid);
    end
  endtask

  task automatic check_byte(input string name, input logic [3:0] addr, input logic [7:0] exp);
    rd_addr = addr;
    #1;
    checks++;
    if (rd_data !== exp) begin
      failures++;
      $display("FAIL %s: rd_data[%0d]=%h required %h", name, addr, rd_data, exp);
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] cmd, input logic [4:0] len);
    checks++;
    if (frame_valid !== 1'b1 || frame_cmd !== cmd || frame_len !== len) begin
      failures++;
      $display("FAIL %s: valid=%b cmd=%h len=%0d required valid=1 cmd=%h len=%0d",
               name, frame_valid, frame_cmd, frame_len, cmd, len);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; frame_ack = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({frame_valid, frame_cmd, frame_len, err_chk, err_len, err_timeout, drop} !== 18'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b cmd=%h len=%0d errs=%b%b%b drop=%b required all 0",
               frame_valid, frame_cmd, frame_len, err_chk, err_len, err_timeout, drop);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_good_frame();
    logic [7:0] q[$];
    int c0, l0, d0;
    c0 = n_err_chk; l0 = n_err_len; d0 = n_drop;
    q = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44};
    send_bytes(q, 1);
    checks++;
    if (frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL good_pre_chk: frame_valid=%b required 0", frame_valid);
    end
    in_data = 8'h65; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_valid !== 1'b1) begin
      failures++;
      $display("FAIL good_latency: frame_valid=%b required 1 one cycle after CHK", frame_valid);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_frame("good_frame", 8'h10, 5'd2);
    check_byte("good_rd0", 4'd0, 8'h33);
    check_byte("good_rd1", 4'd1, 8'h44);
    checks++;
    if (n_err_chk != c0 || n_err_len != l0 || n_drop != d0) begin
      failures++;
      $display("FAIL good_no_err: err_chk=%0d err_len=%0d drop=%0d required 0 0 0",
               n_err_chk - c0, n_err_len - l0, n_drop - d0);
    end
    do_ack();
    $display("test_good_frame: cmd=10 len=2 done");
  endtask

  task automatic test_bad_chk();
    logic [7:0] q[$];
    int c0;
    c0 = n_err_chk;
    q = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h66};
    send_bytes(q, 1);
    checks++;
    if (n_err_chk - c0 != 1 || frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL bad_chk: err_chk pulses=%0d valid=%b required 1 and 0", n_err_chk - c0, frame_valid);
    end
    q = '{8'hA5, 8'h03, 8'h01, 8'h5A, 8'h58};
    send_bytes(q, 1);
    check_frame("after_bad_chk", 8'h03, 5'd1);
    check_byte("after_bad_rd0", 4'd0, 8'h5A);
    do_ack();
    $display("test_bad_chk done");
  endtask

  task automatic test_len_err();
    logic [7:0] q[$];
    int l0;
    l0 = n_err_len;
    q = '{8'hA5, 8'h01, 8'h11};
    send_bytes(q, 1);
    checks++;
    if (n_err_len - l0 != 1 || frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL len_err: err_len pulses=%0d valid=%b required 1 and 0", n_err_len - l0, frame_valid);
    end
    q = '{8'hA5, 8'h07, 8'h00, 8'h07};
    send_bytes(q, 1);
    check_frame("len_zero", 8'h07, 5'd0);
    do_ack();
    // LEN == MAX_LEN is legal: 16 payload bytes 0..15, checksum 0x40^0x10^0x00 = 0x50
    q = '{8'hA5, 8'h40, 8'h10};
    for (int i = 0; i < 16; i++) q.push_back(8'(i));
    q.push_back(8'h50);
    send_bytes(q, 1);
    check_frame("len_max", 8'h40, 5'd16);
    check_byte("len_max_rd15", 4'd15, 8'h0F);
    do_ack();
    $display("test_len_err done");
  endtask

  task automatic test_drop();
    logic [7:0] q[$];
    int d0;
    q = '{8'hA5, 8'h22, 8'h02, 8'hAB, 8'hCD, 8'h46};
    send_bytes(q, 1);
    check_frame("drop_held", 8'h22, 5'd2);
    d0 = n_drop;
    q = '{8'hA5, 8'h99, 8'h01};
    send_bytes(q, 1);
    checks++;
    if (n_drop - d0 != 3) begin
      failures++;
      $display("FAIL drop_count: drop pulses=%0d required 3", n_drop - d0);
    end
    check_frame("drop_unchanged", 8'h22, 5'd2);
    check_byte("drop_rd0", 4'd0, 8'hAB);
    check_byte("drop_rd1", 4'd1, 8'hCD);
    // Ack and strobe in the same cycle: frame clears, byte still dropped.
    in_data = 8'hA5; in_valid = 1'b1; frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (frame_valid !== 1'b0 || n_drop - d0 != 4) begin
      failures++;
      $display("FAIL ack_with_strobe: valid=%b drops=%0d required 0 and 4", frame_valid, n_drop - d0);
    end
    q = '{8'hA5, 8'h30, 8'h00, 8'h30};
    send_bytes(q, 1);
    check_frame("after_drop", 8'h30, 5'd0);
    do_ack();
    $display("test_drop done");
  endtask

  task automatic test_level_hold();
    logic [7:0] q[$];
    int c0;
    c0 = n_err_chk + n_err_len;
    q = '{8'hA5, 8'h10, 8'h02, 8'h33, 8'h44, 8'h65};
    send_bytes(q, 10);
    check_frame("level_hold", 8'h10, 5'd2);
    check_byte("level_rd0", 4'd0, 8'h33);
    check_byte("level_rd1", 4'd1, 8'h44);
    checks++;
    if (n_err_chk + n_err_len != c0) begin
      failures++;
      $display("FAIL level_no_err: error pulses=%0d required 0", n_err_chk + n_err_len - c0);
    end
    do_ack();
    $display("test_level_hold done");
  endtask

  task automatic test_reset_mid();
    logic [7:0] q[$];
    q = '{8'hA5, 8'h10};
    send_bytes(q, 1);
    rst = 1'b1;
    #1;
    checks++;
    if ({frame_valid, frame_cmd, frame_len, err_chk, err_len, err_timeout, drop} !== 18'b0) begin
      failures++;
      $display("FAIL reset_mid: valid=%b cmd=%h len=%0d required 0 0 0", frame_valid, frame_cmd, frame_len);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    q = '{8'hA5, 8'h20, 8'h00, 8'h20};
    send_bytes(q, 1);
    check_frame("after_reset", 8'h20, 5'd0);
    do_ack();
    $display("test_reset_mid done");
  endtask

  task automatic test_timeout();
    logic [7:0] q[$];
    int t0;
    t0 = n_err_to;
    q = '{8'hA5};
    send_bytes(q, 1);
    repeat (210) @(negedge clk);
`ifdef UART_FRAME_TIMEOUT_EN
    checks++;
    if (n_err_to - t0 != 1) begin
      failures++;
      $display("FAIL timeout_pulse: err_timeout pulses=%0d required 1", n_err_to - t0);
    end
    q = '{8'hA5, 8'h20, 8'h00, 8'h20};
`else
    checks++;
    if (n_err_to - t0 != 0) begin
      failures++;
      $display("FAIL timeout_disabled: err_timeout pulses=%0d required 0", n_err_to - t0);
    end
    q = '{8'h20, 8'h00, 8'h20};
`endif
    send_bytes(q, 1);
    check_frame("after_stall", 8'h20, 5'd0);
    do_ack();
    $display("test_timeout done");
  endtask

  task automatic test_pulse_shape();
    checks++;
    if (n_shape != 0) begin
      failures++;
      $display("FAIL pulse_shape: overlapping/long pulses=%0d required 0", n_shape);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_len_err();
    test_drop();
    test_level_hold();
    test_reset_mid();
    test_timeout();
    test_pulse_shape();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
